// File: rtl/lms_delay_line_pkg.sv
// rtl/lms_delay_line_pkg.sv - shared defaults and helpers for the LMS delay line
package lms_delay_line_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int DEPTH_DEF  = 8;

  // Ceiling log2, usable in constant expressions (clog2(9) = 4).
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/delay_line_cell.sv
// rtl/delay_line_cell.sv - one enable/clear sample register of the delay line
module delay_line_cell
  import lms_delay_line_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              en_i,
  input  logic              clr_i,
  input  logic [DATA_W-1:0] d_i,
  output logic [DATA_W-1:0] q_o
);

  logic [DATA_W-1:0] q_q;

  // Sample register: clear wins over enable, async reset empties it.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      q_q <= '0;
    end else if (clr_i) begin
      q_q <= '0;
    end else if (en_i) begin
      q_q <= d_i;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/lms_delay_line.sv
// rtl/lms_delay_line.sv - tapped delay line with runtime-selectable delay output
module lms_delay_line
  import lms_delay_line_pkg::*;
#(
  parameter  int DATA_W = DATA_W_DEF,
  parameter  int DEPTH  = DEPTH_DEF,
  localparam int SEL_W  = clog2(DEPTH + 1)
) (
  input  logic                    Clk,
  input  logic                    Reset,
  input  logic                    Enable,
  input  logic                    Clear,
  input  logic [DATA_W-1:0]       Data_in,
  input  logic [SEL_W-1:0]        Sel,
  output logic [DATA_W-1:0]       Delay_out,
  output logic [DEPTH*DATA_W-1:0] Taps,
  output logic                    Out_valid,
  output logic                    Full
);

  logic [DATA_W-1:0] tap    [DEPTH];
  logic [DATA_W-1:0] cell_d [DEPTH];
  logic              shift_en;

  assign shift_en = Enable & ~Clear;

  for (genvar k = 0; k < DEPTH; k++) begin : g_cell
    if (k == 0) begin : g_head
      assign cell_d[k] = Data_in;
    end else begin : g_chain
      assign cell_d[k] = tap[k-1];
    end

    delay_line_cell #(.DATA_W(DATA_W)) u_cell (
      .Clk   (Clk),
      .Reset (Reset),
      .en_i  (shift_en),
      .clr_i (Clear),
      .d_i   (cell_d[k]),
      .q_o   (tap[k])
    );

    assign Taps[k*DATA_W +: DATA_W] = tap[k];
  end

  logic [SEL_W-1:0]  sel_eff;
  logic [DATA_W-1:0] delay_sel;
  logic [SEL_W-1:0]  fill_sat;

  logic [SEL_W-1:0]  fill_q,  fill_d;
  logic [DATA_W-1:0] delay_q, delay_d;
  logic              valid_q, valid_d;
  logic              full_q,  full_d;

  // Clamp the requested delay into 1..DEPTH.
  always_comb begin
    sel_eff = Sel;
    if (Sel == '0) begin
      sel_eff = SEL_W'(1);
    end else if (Sel > SEL_W'(DEPTH)) begin
      sel_eff = SEL_W'(DEPTH);
    end
  end

  // Pick the pre-edge tap that becomes tap[sel_eff-1] after the shift.
  always_comb begin
    delay_sel = Data_in;
    for (int k = 0; k < DEPTH - 1; k++) begin
      if (sel_eff == SEL_W'(k + 2)) begin
        delay_sel = tap[k];
      end
    end
  end

  assign fill_sat = (fill_q == SEL_W'(DEPTH)) ? fill_q : fill_q + SEL_W'(1);

  // Next state of the output registers and fill counter.
  always_comb begin
    fill_d  = fill_q;
    delay_d = delay_q;
    valid_d = 1'b0;
    full_d  = full_q;
    if (Clear) begin
      fill_d  = '0;
      delay_d = '0;
      full_d  = 1'b0;
    end else if (Enable) begin
      fill_d  = fill_sat;
      delay_d = delay_sel;
      valid_d = (fill_sat >= sel_eff);
      full_d  = (fill_sat == SEL_W'(DEPTH));
    end
  end

  // Output and fill-count registers.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      fill_q  <= '0;
      delay_q <= '0;
      valid_q <= 1'b0;
      full_q  <= 1'b0;
    end else begin
      fill_q  <= fill_d;
      delay_q <= delay_d;
      valid_q <= valid_d;
      full_q  <= full_d;
    end
  end

  assign Delay_out = delay_q;
  assign Out_valid = valid_q;
  assign Full      = full_q;

endmodule

// File: tb/tb_lms_delay_line.sv
// tb/tb_lms_delay_line.sv - directed self-checking bench for lms_delay_line
module tb_lms_delay_line;

  logic         Clk = 1'b0;
  logic         Reset;
  logic         Enable;
  logic         Clear;
  logic [15:0]  Data_in;
  logic [3:0]   Sel;
  logic [15:0]  Delay_out;
  logic [127:0] Taps;
  logic         Out_valid;
  logic         Full;

  int n_vec  = 0;
  int n_fail = 0;

  lms_delay_line #(.DATA_W(16), .DEPTH(8)) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .Enable    (Enable),
    .Clear     (Clear),
    .Data_in   (Data_in),
    .Sel       (Sel),
    .Delay_out (Delay_out),
    .Taps      (Taps),
    .Out_valid (Out_valid),
    .Full      (Full)
  );

  always #5 Clk = ~Clk;

  task automatic strobe(input logic [15:0] d, input logic [3:0] s);
    @(negedge Clk);
    Data_in = d;
    Sel     = s;
    Enable  = 1'b1;
    @(posedge Clk);
    #1;
    Enable  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  task automatic test_reset;
    Reset = 1'b0;
    Clear = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge Clk);
      Enable  = 1'($urandom);
      Clear   = 1'($urandom);
      Data_in = 16'($urandom);
      Sel     = 4'($urandom);
      @(posedge Clk);
      #1;
      n_vec++;
      if (Delay_out !== 16'h0 || Taps !== 128'h0 || Out_valid !== 1'b0 || Full !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_hold: Delay_out=%h Taps=%h Out_valid=%b Full=%b, required all 0", Delay_out, Taps, Out_valid, Full);
      end
    end
    @(negedge Clk);
    Enable = 1'b0;
    Clear  = 1'b0;
    Reset  = 1'b1;
  endtask

  task automatic test_sel1;
    logic [15:0] vals [3];
    vals[0] = 16'h0011;
    vals[1] = 16'h0022;
    vals[2] = 16'h0033;
    for (int i = 0; i < 3; i++) begin
      strobe(vals[i], 4'd1);
      n_vec++;
      if (Delay_out !== vals[i] || Out_valid !== 1'b1 || Taps[15:0] !== vals[i]) begin
        n_fail++;
        $display("FAIL sel1_strobe%0d: Delay_out=%h Out_valid=%b tap0=%h, required %h 1 %h", i, Delay_out, Out_valid, Taps[15:0], vals[i], vals[i]);
      end
    end
    idle(1);
    n_vec++;
    if (Out_valid !== 1'b0 || Delay_out !== 16'h0033) begin
      n_fail++;
      $display("FAIL sel1_idle: Out_valid=%b Delay_out=%h, required 0 0033", Out_valid, Delay_out);
    end
  endtask

  task automatic do_clear;
    @(negedge Clk);
    Clear = 1'b1;
    @(posedge Clk);
    #1;
    Clear = 1'b0;
  endtask

  task automatic test_sel8_fill;
    logic [15:0] exp_d;
    do_clear();
    for (int i = 1; i <= 10; i++) begin
      strobe(16'(i), 4'd8);
      exp_d = (i >= 8) ? 16'(i - 7) : 16'h0;
      n_vec++;
      if (Delay_out !== exp_d || Out_valid !== (i >= 8) || Full !== (i >= 8)) begin
        n_fail++;
        $display("FAIL sel8_strobe%0d: Delay_out=%h Out_valid=%b Full=%b, required %h %b %b", i, Delay_out, Out_valid, Full, exp_d, (i >= 8), (i >= 8));
      end
      idle(2);
      n_vec++;
      if (Delay_out !== exp_d || Out_valid !== 1'b0 || Full !== (i >= 8) || Taps[15:0] !== 16'(i)) begin
        n_fail++;
        $display("FAIL sel8_gap%0d: Delay_out=%h Out_valid=%b Full=%b tap0=%h, required %h 0 %b %h", i, Delay_out, Out_valid, Full, Taps[15:0], exp_d, (i >= 8), 16'(i));
      end
    end
  endtask

  task automatic test_sel_clamp;
    do_clear();
    strobe(16'h00AA, 4'd0);
    n_vec++;
    if (Delay_out !== 16'h00AA || Out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL sel0_as_1: Delay_out=%h Out_valid=%b, required 00aa 1", Delay_out, Out_valid);
    end
    strobe(16'h00B1, 4'd15);
    n_vec++;
    if (Delay_out !== 16'h0000 || Out_valid !== 1'b0 || Full !== 1'b0) begin
      n_fail++;
      $display("FAIL sel15_early: Delay_out=%h Out_valid=%b Full=%b, required 0000 0 0", Delay_out, Out_valid, Full);
    end
    for (int i = 2; i <= 7; i++) strobe(16'(16'h00B0 + i), 4'd15);
    n_vec++;
    if (Delay_out !== 16'h00AA || Out_valid !== 1'b1 || Full !== 1'b1) begin
      n_fail++;
      $display("FAIL sel15_as_8: Delay_out=%h Out_valid=%b Full=%b, required 00aa 1 1", Delay_out, Out_valid, Full);
    end
    @(negedge Clk);
    Sel = 4'd1;
    Data_in = 16'hDEAD;
    idle(2);
    n_vec++;
    if (Delay_out !== 16'h00AA || Taps[15:0] !== 16'h00B7 || Taps[127:112] !== 16'h00AA) begin
      n_fail++;
      $display("FAIL sel_change_idle: Delay_out=%h tap0=%h tap7=%h, required 00aa 00b7 00aa", Delay_out, Taps[15:0], Taps[127:112]);
    end
  endtask

  task automatic test_clear_priority;
    @(negedge Clk);
    Clear   = 1'b1;
    Enable  = 1'b1;
    Data_in = 16'h7FFF;
    @(posedge Clk);
    #1;
    Clear  = 1'b0;
    Enable = 1'b0;
    n_vec++;
    if (Delay_out !== 16'h0 || Taps !== 128'h0 || Out_valid !== 1'b0 || Full !== 1'b0) begin
      n_fail++;
      $display("FAIL clear_prio: Delay_out=%h Taps=%h Out_valid=%b Full=%b, required all 0", Delay_out, Taps, Out_valid, Full);
    end
    strobe(16'h0005, 4'd2);
    n_vec++;
    if (Taps[15:0] !== 16'h0005 || Out_valid !== 1'b0 || Delay_out !== 16'h0 || Full !== 1'b0) begin
      n_fail++;
      $display("FAIL clear_then_strobe: tap0=%h Out_valid=%b Delay_out=%h Full=%b, required 0005 0 0000 0", Taps[15:0], Out_valid, Delay_out, Full);
    end
  endtask

  task automatic test_async_reset;
    strobe(16'h1234, 4'd1);
    n_vec++;
    if (Delay_out !== 16'h1234 || Out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL pre_reset: Delay_out=%h Out_valid=%b, required 1234 1", Delay_out, Out_valid);
    end
    #2;
    Reset = 1'b0;
    #1;
    n_vec++;
    if (Delay_out !== 16'h0 || Taps !== 128'h0 || Out_valid !== 1'b0 || Full !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset: Delay_out=%h Taps=%h Out_valid=%b Full=%b, required all 0", Delay_out, Taps, Out_valid, Full);
    end
    @(negedge Clk);
    Reset = 1'b1;
    strobe(16'h0042, 4'd2);
    n_vec++;
    if (Taps[15:0] !== 16'h0042 || Taps[31:16] !== 16'h0 || Out_valid !== 1'b0 || Delay_out !== 16'h0) begin
      n_fail++;
      $display("FAIL post_reset: tap0=%h tap1=%h Out_valid=%b Delay_out=%h, required 0042 0000 0 0000", Taps[15:0], Taps[31:16], Out_valid, Delay_out);
    end
  endtask

  initial begin
    Reset   = 1'b0;
    Enable  = 1'b0;
    Clear   = 1'b0;
    Data_in = 16'h0;
    Sel     = 4'd1;
    test_reset();
    test_sel1();
    test_sel8_fill();
    test_sel_clamp();
    test_clear_priority();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/lms_delay_line.md
LMS_DELAY_LINE -- requirements
Module: lms_delay_line

Interface
REQ-001 SHALL have parameter DATA_W, default 16, sample width in bits.
REQ-002 SHALL have parameter DEPTH, default 8, number of delay taps, legal range 2..64.
REQ-003 SHALL have derived constant SEL_W = clog2(DEPTH+1), the width of the delay-select port.
REQ-004 SHALL have port Clk  input  1  clock, all state on rising edge.
REQ-005 SHALL have port Reset  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port Enable  input  1  sample strobe; shift line when high.
REQ-007 SHALL have port Clear  input  1  synchronous flush of all state.
REQ-008 SHALL have port Data_in  input  DATA_W  new sample, two's complement.
REQ-009 SHALL have port Sel  input  SEL_W  runtime delay in strobes, 1..DEPTH.
REQ-010 SHALL have port Delay_out  output  DATA_W  registered sample delayed by Sel strobes.
REQ-011 SHALL have port Taps  output  DEPTH*DATA_W  flattened tap array; tap[k] occupies bits [k*DATA_W +: DATA_W].
REQ-012 SHALL have port Out_valid  output  1  one-cycle pulse when Delay_out holds a real sample.
REQ-013 SHALL have port Full  output  1  level, high while fill count equals DEPTH.

Function
REQ-014 SHALL shift on any edge with Enable=1 and Clear=0: tap[0]<=Data_in, tap[k]<=tap[k-1] for k=1..DEPTH-1.
REQ-015 SHALL hold all taps, Delay_out, fill count and Full unchanged when Enable=0.
REQ-016 SHALL compute Sel_eff = 1 if Sel=0, DEPTH if Sel>DEPTH, otherwise Sel.
REQ-017 SHALL, on a shift edge, load Delay_out with Data_in if Sel_eff=1, else with the pre-edge tap[Sel_eff-2]; Delay_out thus equals tap[Sel_eff-1] after the edge.
REQ-018 SHALL sample Sel only on shift edges; a Sel change between strobes SHALL NOT alter Delay_out or the taps.
REQ-019 SHALL keep a fill counter of shifts since reset or Clear, saturating at DEPTH (no wrap-around).
REQ-020 SHALL, on a shift edge, set Out_valid to 1 iff min(fill+1, DEPTH) >= Sel_eff; Out_valid SHALL be 0 on every other edge (pulse, not level).
REQ-021 SHALL drive Full high when fill=DEPTH, as a registered level.
REQ-022 SHALL give Clear priority over Enable: when both are high, all taps, Delay_out, fill, Full and Out_valid go to 0 and the Data_in sample is dropped.
REQ-023 SHALL keep Data_in passing through unmodified, with no arithmetic, rounding or sign extension.

Reset
REQ-024 SHALL, while Reset=0, asynchronously force all taps, Delay_out, fill count, Out_valid and Full to 0, including mid-stream.
REQ-025 SHALL resume normal operation on the first rising Clk edge after Reset deasserts, with the line empty.

Structure
REQ-026 SHALL place the DATA_W/DEPTH defaults and the clog2 function in the shared lms package.
REQ-027 SHALL build the tap storage from DEPTH instances of one sub-module, delay_line_cell, an enable/clear DATA_W register with asynchronous active-low reset.
REQ-028 SHALL keep the Sel clamp, the fill counter and the output registers in the top module.

Verification (DATA_W=16, DEPTH=8)
REQ-029 SHALL cover: Reset=0 with random inputs -> Delay_out=0, Taps=0, Out_valid=0, Full=0.
REQ-030 SHALL cover: Sel=1, strobes of 0x0011, 0x0022, 0x0033 -> Delay_out follows each sample at its edge; Out_valid pulses on each strobe.
REQ-031 SHALL cover: Sel=8, strobes of 1..10 with idle gaps -> first Out_valid and Full at strobe 8 with Delay_out=1; strobe 10 gives Delay_out=3; outputs hold during gaps.
REQ-032 SHALL cover: Sel=0 -> behaves as Sel=1; Sel=15 -> behaves as Sel=8.
REQ-033 SHALL cover: line full, Clear=1 and Enable=1 with Data_in=0x7FFF -> all outputs 0, Full=0, next strobe of 0x0005 gives tap[0]=5 with no Out_valid at Sel=2.
REQ-034 SHALL cover: Reset pulsed low between edges mid-stream -> outputs 0 immediately, before the next Clk edge.
